// File: rtl/alu_issue_ctrl.sv
// Issues register-file instructions to an external 16-bit combinational ALU and returns results.
// Latency: loads respond one edge after acceptance, ALU ops two edges after acceptance.
// Backpressure: one instruction in flight; in_ready stays low until the result is taken by out_ready.
module alu_issue_ctrl #(
    parameter  int WIDTH = 16,
    parameter  int NREG  = 4,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,

    // instruction channel
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_ld,
    input  logic [RAW-1:0]   in_rd,
    input  logic [RAW-1:0]   in_rs,
    input  logic [RAW-1:0]   in_rt,
    input  logic [WIDTH-1:0] in_imm,

    // external ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,

    // result channel
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [RAW-1:0]   out_rd,
    output logic             out_carry,

    output logic [7:0]       op_count
);

    // ALU select encodings
    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Result record presented on the output channel; held stable while in RESP.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [RAW-1:0]   rd;
        logic             carry;
    } rsp_t;

    state_t           state;
    rsp_t             rsp_q;
    logic             rsp_vld;
    logic [RAW-1:0]   exec_rd;
    logic [WIDTH-1:0] regs [NREG];
    logic [7:0]       done_cnt;

    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             sub_borrow;
    logic             carry_nxt;

    // Carry/borrow are derived locally from the registered operands, not from the ALU.
    // A wrapped sum smaller than an addend means bit WIDTH of the full sum was set.
    assign add_sum    = alu_a + alu_b;
    assign add_carry  = (add_sum < alu_a);
    assign sub_borrow = (alu_a < alu_b);

    // Select which flag accompanies the result of the op currently in EXEC.
    always_comb begin
        carry_nxt = 1'b0;
        case (alu_sel)
            SEL_ADD: carry_nxt = add_carry;
            SEL_SUB: carry_nxt = sub_borrow;
            default: carry_nxt = 1'b0;
        endcase
    end

    // Ready depends on state alone, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state == IDLE);

    assign out_valid = rsp_vld;
    assign out_data  = rsp_q.data;
    assign out_rd    = rsp_q.rd;
    assign out_carry = rsp_q.carry;
    assign op_count  = done_cnt;

    // Controller FSM with its registered outputs and the register file.
    // Operands are read at acceptance, so rd may alias rs/rt; writeback lands before the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rsp_q    <= '0;
            rsp_vld  <= 1'b0;
            exec_rd  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= SEL_ADD;
            done_cnt <= 8'd0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_ld) begin
                            // Immediate load bypasses the ALU and responds on the next cycle.
                            regs[in_rd]  <= in_imm;
                            rsp_q.data   <= in_imm;
                            rsp_q.rd     <= in_rd;
                            rsp_q.carry  <= 1'b0;
                            rsp_vld      <= 1'b1;
                            state        <= RESP;
                        end else begin
                            alu_a   <= regs[in_rs];
                            alu_b   <= regs[in_rt];
                            alu_sel <= in_op;
                            exec_rd <= in_rd;
                            state   <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    // Operands have been stable on the ALU for a full cycle; capture its result.
                    regs[exec_rd] <= alu_result;
                    rsp_q.data    <= alu_result;
                    rsp_q.rd      <= exec_rd;
                    rsp_q.carry   <= carry_nxt;
                    rsp_vld       <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    if (out_ready) begin
                        rsp_vld  <= 1'b0;
                        done_cnt <= done_cnt + 8'd1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    rsp_vld <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU attached.
// Latency: n/a.
// Backpressure: exercises held out_ready and ignored in_valid while a result is pending.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_ld;
    logic [1:0]  in_rd;
    logic [1:0]  in_rs;
    logic [1:0]  in_rt;
    logic [15:0] in_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_rd;
    logic        out_carry;
    logic [7:0]  op_count;

    int checks;
    int failures;
    int exp_count;
    int lat;

    alu_issue_ctrl #(.WIDTH(16), .NREG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ld      (in_ld),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_carry  (out_carry),
        .op_count   (op_count)
    );

    // External combinational ALU the controller drives.
    always_comb begin
        alu_result = 16'h0000;
        case (alu_sel)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one instruction from a negedge; returns edges from acceptance to out_valid.
    task automatic issue(input logic ld, input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input logic [1:0] rt, input logic [15:0] imm,
                         output int edges);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_before_issue", in_ready, 1);
        in_valid = 1'b1;
        in_ld    = ld;
        in_op    = op;
        in_rd    = rd;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Check the pending result, accept it, and confirm the return to IDLE.
    task automatic take(input string tag, input logic [15:0] data, input logic [1:0] rd,
                        input logic carry);
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_data"}, out_data, data);
        check_eq({tag, "_rd"}, out_rd, rd);
        check_eq({tag, "_carry"}, out_carry, carry);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count++;
        check_eq({tag, "_count"}, op_count, exp_count % 256);
        check_eq({tag, "_valid_drop"}, out_valid, 0);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [1:0] rd, input logic [15:0] imm);
        int e;
        issue(1'b1, 2'b00, rd, 2'd0, 2'd0, imm, e);
        check_eq("load_latency", e, 1);
        take("load", imm, rd, 1'b0);
    endtask

    task automatic do_alu(input string tag, input logic [1:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic [1:0] rt,
                          input logic [15:0] data, input logic carry);
        int e;
        issue(1'b0, op, rd, rs, rt, 16'h0000, e);
        check_eq({tag, "_latency"}, e, 2);
        take(tag, data, rd, carry);
    endtask

    // OR of a register with itself returns its contents unchanged.
    task automatic read_reg(input string tag, input logic [1:0] r, input logic [15:0] exp);
        do_alu(tag, 2'b11, r, r, r, exp, 1'b0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_ld     = 1'b0;
        in_rd     = 2'd0;
        in_rs     = 2'd0;
        in_rt     = 2'd0;
        in_imm    = 16'h0000;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_rd", out_rd, 0);
        check_eq("rst_out_carry", out_carry, 0);
        check_eq("rst_op_count", op_count, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_sel", alu_sel, 0);

        // single load
        do_load(2'd1, 16'h1234);
        check_eq("first_count", op_count, 1);

        // add with carry-out and wrap to zero
        do_load(2'd0, 16'hFFFF);
        do_load(2'd1, 16'h0001);
        issue(1'b0, 2'b00, 2'd2, 2'd0, 2'd1, 16'h0000, lat);
        check_eq("add_latency", lat, 2);
        check_eq("add_alu_a", alu_a, 16'hFFFF);
        check_eq("add_alu_b", alu_b, 16'h0001);
        check_eq("add_alu_sel", alu_sel, 2'b00);
        take("add", 16'h0000, 2'd2, 1'b1);
        read_reg("read_r2", 2'd2, 16'h0000);
        check_eq("alu_sel_hold", alu_sel, 2'b11);

        // subtract with and without borrow
        do_load(2'd0, 16'h0003);
        do_load(2'd1, 16'h0005);
        do_alu("sub_borrow", 2'b01, 2'd3, 2'd0, 2'd1, 16'hFFFE, 1'b1);
        do_alu("sub_noborrow", 2'b01, 2'd3, 2'd1, 2'd0, 16'h0002, 1'b0);

        // logic ops, rd aliasing rs, and a dependent add
        do_load(2'd0, 16'hF0F0);
        do_load(2'd1, 16'h0FF0);
        do_alu("and", 2'b10, 2'd2, 2'd0, 2'd1, 16'h00F0, 1'b0);
        do_alu("or_alias", 2'b11, 2'd0, 2'd0, 2'd1, 16'hFFF0, 1'b0);
        do_alu("add_dep", 2'b00, 2'd3, 2'd0, 2'd1, 16'h0FE0, 1'b1);

        // out_ready asserted early is harmless
        out_ready = 1'b1;
        issue(1'b0, 2'b10, 2'd2, 2'd0, 2'd0, 16'h0000, lat);
        check_eq("early_rdy_latency", lat, 2);
        check_eq("early_rdy_count", op_count, exp_count % 256);
        take("early_rdy", 16'hFFF0, 2'd2, 1'b0);

        // backpressure: result held, new instruction ignored
        issue(1'b1, 2'b00, 2'd2, 2'd0, 2'd0, 16'hABCD, lat);
        check_eq("bp_latency", lat, 1);
        in_valid = 1'b1;
        in_ld    = 1'b1;
        in_rd    = 2'd3;
        in_imm   = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_valid", out_valid, 1);
            check_eq("bp_data", out_data, 16'hABCD);
            check_eq("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        take("bp", 16'hABCD, 2'd2, 1'b0);
        read_reg("bp_r3_untouched", 2'd3, 16'h0FE0);

        // counter wrap
        while (exp_count < 255) begin
            do_load(2'd1, exp_count[15:0]);
        end
        check_eq("count_255", op_count, 255);
        do_load(2'd1, 16'h00FF);
        check_eq("count_wrap", op_count, 0);

        // reset during EXEC discards the op
        do_load(2'd1, 16'h7777);
        in_valid = 1'b1;
        in_ld    = 1'b0;
        in_op    = 2'b00;
        in_rd    = 2'd2;
        in_rs    = 2'd1;
        in_rt    = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("exec_in_ready", in_ready, 0);
        check_eq("exec_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_count", op_count, 0);
        check_eq("midrst_alu_a", alu_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("postrst_valid", out_valid, 0);
        end
        read_reg("postrst_r2", 2'd2, 16'h0000);
        read_reg("postrst_r1", 2'd1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 16-bit ALU operand/select interface. Accepts instructions over a valid/ready handshake and reads operands from a small internal register file. Drives a, b and sel to an external combinational ALU, captures the result plus a locally computed carry/borrow, writes it back, and returns it over a second valid/ready handshake. Sits between the instruction source (host/testbench/decoder) and the ALU.

Parameters:
WIDTH, 16, datapath width; must match ALU operand width
NREG, 4, register-file entries (index width RAW = 2)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  controller can accept an instruction
in_op  in  2  ALU select: 00 add, 01 sub, 10 and, 11 or
in_ld  in  1  1 = load immediate (no ALU use)
in_rd  in  2  destination register index
in_rs  in  2  operand-A register index
in_rt  in  2  operand-B register index
in_imm  in  16  immediate for load
alu_a  out  16  ALU operand A (registered)
alu_b  out  16  ALU operand B (registered)
alu_sel  out  2  ALU select (registered)
alu_result  in  16  combinational ALU result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  16  result written to rd
out_rd  out  2  destination index of result
out_carry  out  1  add: carry-out; sub: borrow (a<b unsigned); and/or: 0; load: 0
op_count  out  8  completed-instruction counter

Behaviour:
- Reset (async, rst_n=0): state IDLE; regfile all 0; alu_a/alu_b/out_data 0; alu_sel 00; out_rd 0; out_valid 0; out_carry 0; op_count 0; in_ready 1 once rst_n is deasserted.
- FSM states: IDLE, EXEC, RESP. in_ready = (state==IDLE), combinational from state only.
- IDLE, accept on in_valid&in_ready at edge N:
  - in_ld=1: reg[rd]<=imm, out_data<=imm, out_rd<=rd, out_carry<=0 -> RESP (out_valid high from edge N, visible cycle N+1).
  - in_ld=0: alu_a<=reg[rs], alu_b<=reg[rt], alu_sel<=op, latch rd -> EXEC.
- EXEC (one cycle): at next edge reg[rd]<=alu_result, out_data<=alu_result, out_rd<=rd. out_carry: add = bit16 of {1'b0,alu_a}+{1'b0,alu_b}; sub = (alu_a<alu_b); else 0 -> RESP.
- ALU op latency: out_valid asserted from edge N+2 after acceptance edge N; load latency one edge.
- RESP: out_valid=1, out_data/out_rd/out_carry held stable until out_valid&out_ready. On handshake: op_count<=op_count+1 (wraps 255->0), out_valid<=0 -> IDLE. Next accept possible at the following edge (max one instruction per 3 cycles for ALU ops, 2 for loads).
- out_ready high before out_valid is ignored; no combinational path from out_ready to in_ready.
- Hazards: rs/rt read at acceptance, so rd==rs or rd==rt is legal (old value used, new value written). A back-to-back instruction sees the prior write because writeback precedes next accept.
- Arithmetic wraps modulo 2^16; regfile write only in IDLE (load) or EXEC.
- alu_a/alu_b/alu_sel hold their last values outside EXEC.
- rst_n asserted in any state: immediate return to reset values; in-flight instruction discarded, no result emitted.

Test Plan:
- Reset then load r1=0x1234 -> out_valid 1 cycle after accept, out_data=0x1234, out_rd=1, out_carry=0, op_count=1.
- Load r0=0xFFFF, r1=0x0001; add rd=2, rs=0, rt=1 -> out_data=0x0000, out_carry=1, r2=0; out_valid two edges after accept.
- Load r0=0x0003, r1=0x0005; sub rd=3, rs=0, rt=1 -> out_data=0xFFFE, out_carry=1; swap operands -> out_data=0x0002, out_carry=0.
- r0=0xF0F0, r1=0x0FF0: and -> 0x00F0; or -> 0xFFF0; carry 0; rd=rs=0 for or -> r0 becomes 0xFFF0; subsequent add r0+r1 uses 0xFFF0.
- Hold out_ready=0 for 5 cycles in RESP -> out_valid/out_data stable, in_ready=0, in_valid ignored; release -> IDLE; 256 completions wrap op_count to 0.
- Assert rst_n=0 during EXEC -> out_valid stays 0, regfile all 0, in_ready=1 after release, destination register unchanged from reset value.
